// File: rtl/mac512_result_unloader.sv
// Result unloader: captures a wide MAC product and drains it LSW-first as
// narrow words over valid/ready, absorbing bus backpressure for the MAC.
module mac512_result_unloader #(
  parameter  int DATA_W    = 512,
  parameter  int WORD_W    = 32,
  localparam int NUM_WORDS = DATA_W / WORD_W,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                overrun_q, overrun_d;
  logic [WORD_W-1:0]   words [NUM_WORDS];
  logic                last_word;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
    assign words[gi] = hold_q[gi*WORD_W +: WORD_W];
  end

  // All outputs decode registered state; only in_ready looks at out_ready,
  // so a new product can slip in on the edge the last word leaves.
  assign last_word = (idx_q == LAST_IDX);
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && last_word;
  assign out_data  = words[idx_q];
  assign overrun   = overrun_q;
  assign in_ready  = (state_q == IDLE) || ((state_q == SEND) && last_word && out_ready);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (in_valid & ~in_ready);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_word) begin
            // Index returns to 0 whether we reload or go idle.
            idx_d = '0;
            if (in_valid) begin
              hold_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_mac512_result_unloader.sv
// Bench for mac512_result_unloader: directed table, corner sequences and
// random traffic checked against a word-queue reference model.
module tb_mac512_result_unloader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [511:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         overrun;
  logic         busy;

  mac512_result_unloader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: words still owed to the bus, in order; front is the current word.
  logic [31:0] mq[$];
  logic        m_ovr = 1'b0;
  int          xlog[$];

  typedef struct {
    logic         v;
    logic [511:0] d;
    logic         r;
    logic         exp_valid;
    logic [3:0]   exp_idx;
    logic [31:0]  exp_data;
    logic         exp_last;
    logic         exp_ready;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [511:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("out_valid", 32'(out_valid), 32'(n > 0));
    chk("busy", 32'(busy), 32'(n > 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("in_ready", 32'(in_ready), 32'((n == 0) || (n == 1 && out_ready)));
    chk("out_idx", 32'(out_idx), (n > 0) ? 32'(16 - n) : 32'd0);
    chk("out_last", 32'(out_last), 32'(n == 1));
    if (n > 0) chk("out_data", out_data, mq[0]);
  endtask

  task automatic advance();
    int  n;
    bit  xfer, rdy;
    n    = mq.size();
    xfer = (n > 0) && out_ready;
    rdy  = (n == 0) || (n == 1 && out_ready);
    if (in_valid && !rdy) m_ovr = 1'b1;
    if (xfer) begin
      xlog.push_back(int'(out_idx));
      void'(mq.pop_front());
    end
    if (in_valid && rdy) begin
      for (int w = 0; w < 16; w++) mq.push_back(in_data[w*32 +: 32]);
      $display("accept product lsw=0x%08h msw=0x%08h t=%0t", in_data[31:0], in_data[511:480], $time);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [511:0] d, input logic r);
    drive(v, d, r);
    check_model();
    advance();
  endtask

  logic [511:0] big;
  logic [511:0] ones;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    big = '0; big[511] = 1'b1; big[0] = 1'b1;
    ones = '1;

    // Single product 100*100 with no backpressure.
    tbl[0] = '{1'b1, 512'd10000, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{1'b0, 512'd0, 1'b1, 1'b1, 4'(i - 1),
                 (i == 1) ? 32'h0000_2710 : 32'd0, 1'(i == 16), 1'(i == 16)};
    tbl[17] = '{1'b0, 512'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check_model();
    chk("rst_out_data", out_data, 32'd0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_idx", 32'(out_idx), 32'(tbl[i].exp_idx));
      chk("tbl_last", 32'(out_last), 32'(tbl[i].exp_last));
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].exp_ready));
      if (tbl[i].exp_valid) chk("tbl_data", out_data, tbl[i].exp_data);
      check_model();
      advance();
    end

    // Backpressure: two stalls per word, word 0 must hold 0x32.
    xlog.delete();
    cycle(1'b1, 512'd50, 1'b0);
    for (int i = 0; i < 48; i++) begin
      drive(1'b0, '0, (i % 3) == 2);
      if (i < 3) chk("bp_word0_hold", out_data, 32'h32);
      check_model();
      advance();
    end
    chk("bp_xfers", 32'(xlog.size()), 32'd16);
    for (int i = 0; i < xlog.size() && i < 16; i++) chk("bp_idx_order", 32'(xlog[i]), 32'(i));
    cycle(1'b0, '0, 1'b1);

    // Back-to-back: second product lands on the first's last-word edge.
    cycle(1'b1, 512'd1024, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    drive(1'b1, big, 1'b1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    check_model();
    advance();
    drive(1'b0, '0, 1'b1);
    chk("b2b_first", out_data, 32'd1);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    check_model();
    advance();
    for (int i = 1; i < 15; i++) cycle(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("b2b_msw", out_data, 32'h8000_0000);
    check_model();
    advance();
    cycle(1'b0, '0, 1'b1);

    // Overrun at idx 5 of an all-ones stream.
    cycle(1'b1, ones, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    drive(1'b1, 512'h1234, 1'b1);
    chk("ovr_ready_idx5", 32'(in_ready), 32'd0);
    check_model();
    advance();
    for (int i = 6; i < 16; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-stream at idx 7.
    cycle(1'b1, 512'hABCD_0001, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    mq.delete(); m_ovr = 1'b0;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("arst_ready", 32'(in_ready), 32'd1);
    check_model();
    advance();
    cycle(1'b1, 512'h5555_6666_7777, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1);

    // Idle stability.
    for (int i = 0; i < 100; i++) cycle(1'b0, '0, 1'($urandom_range(0, 1)));

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [511:0] rd;
      for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom;
      cycle(($urandom_range(0, 7) == 0), rd, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac512_result_unloader.md
Name: mac512_result_unloader

Overview:
- Downstream stage of the 256x256 radix-4 ripple-carry MAC.
- Captures each 512-bit product when the MAC flags it complete.
- Streams the product out as 32-bit words, least-significant word first, over a valid/ready interface to the system bus.
- Frees the MAC from bus backpressure: a product is held here until it is fully drained.

Parameters:
- DATA_W, 512, width of the product captured from the MAC.
- WORD_W, 32, width of each output word; DATA_W must be an integer multiple of WORD_W.
- NUM_WORDS, DATA_W/WORD_W (16), words per product; derived, not overridden.
- IDX_W, clog2(NUM_WORDS) (4), width of the word index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  MAC product valid; a one-cycle pulse at MAC completion.
- in_data  input  DATA_W  MAC product (MAC out).
- in_ready  output  1  unloader can accept a product this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WORD_W  current product word.
- out_idx  output  IDX_W  index of the current word (0 = LSW).
- out_last  output  1  current word is index NUM_WORDS-1.
- overrun  output  1  sticky: a product arrived while in_ready was low.
- busy  output  1  a product is held and not fully drained.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, overrun=0, busy=0.
  - Holding register is cleared to 0; in_ready=1 (decoded from IDLE).
  - Reset mid-stream abandons the held product; no further words are emitted.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1; busy=1.
- Capture:
  - IDLE and in_valid=1 at a clock edge: latch in_data into the holding register, set out_idx=0 and move to SEND.
  - out_valid rises on the cycle after capture, so capture-to-first-word latency is 1 cycle.
- Word transfer: a transfer occurs on any edge where out_valid=1 and out_ready=1.
  - Transfer with out_idx<NUM_WORDS-1: out_idx increments.
  - out_valid=1 with out_ready=0: out_data, out_idx and out_last hold stable. out_valid never drops without a transfer.
- Word select: out_data = holding[out_idx*WORD_W +: WORD_W]; out_last = (out_idx==NUM_WORDS-1). Both are registered or decoded from registered state; neither is driven combinationally from in_*.
- Back-to-back products:
  - in_ready is also 1 in SEND when out_last=1 and out_ready=1, i.e. the last word is transferring this cycle.
  - If in_valid=1 on that edge, the new product is latched, out_idx wraps to 0, and SEND is kept with no bubble.
  - Otherwise the last-word transfer returns the block to IDLE, and out_valid=0 on the next cycle.
- Overrun:
  - in_valid=1 with in_ready=0: the product is dropped, the holding register is untouched, and overrun is set.
  - overrun stays set until rst.
- Simultaneous events: capture and last-word transfer on the same edge resolve as back-to-back above. Nothing else can coincide.
- Widths: no arithmetic on data; out_idx wraps modulo NUM_WORDS only via the back-to-back reload.
- Throughput: with out_ready held at 1, one product per NUM_WORDS cycles (16).

Test Plan:
- Single product, no backpressure: rst pulse; in_valid with in_data=10000 (100*100); out_ready=1.
  - Required: 16 words on consecutive cycles, first word 1 cycle after capture.
  - Word 0 = 0x00002710, words 1..15 = 0, out_last only on idx 15.
  - Then IDLE, in_ready=1.
- Backpressure: in_data=50 (5*10); toggle out_ready 1,0,0,1,...
  - Required: word 0 = 0x32 held stable through both stalled cycles.
  - Exactly 16 transfers, idx strictly 0..15 with no repeats.
- Back-to-back: first product 1024 (32*32); second product 2^511+1 pulsed on the edge where the first product's word 15 transfers.
  - Required: no gap between products; second stream is word 0 = 1, word 15 = 0x80000000.
- Overrun: in_valid pulse at word idx 5 of a stream carrying 0xFFFF...F.
  - Required: overrun=1 and stays set; all 16 words = 0xFFFFFFFF unchanged; in_ready=0 at idx 5.
- Reset mid-stream: assert rst asynchronously between edges at idx 7.
  - Required: out_valid=0 and out_idx=0 immediately, without waiting for clk; overrun=0; in_ready=1 after release.
  - A new product afterwards streams from idx 0.
- Idle stability: in_valid=0 for 100 cycles with out_ready toggling.
  - Required: out_valid=0, out_idx=0, busy=0 throughout.
